// File: rtl/mem_access_stage.sv
// EX/MEM memory-access stage: req/ack data-memory transaction with wait states and timeout.
// Optional define MISALIGN_TRAP_EN adds a sticky ErrMisalign trap for unaligned accesses.
module mem_access_stage #(
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic              CLK,
   input  logic              RSTB,
   input  logic              ExValid,
   input  logic [DATA_W-1:0] ALUResult,
   input  logic [DATA_W-1:0] StoreData,
   input  logic              Dmem1ALUOUT,
   input  logic              DmemREB,
   input  logic              DmemWEB,
   input  logic [4:0]        RdIn,
   input  logic              RegWriteIn,
   output logic              MemREB,
   output logic              MemWEB,
   output logic [DATA_W-1:0] MemAddr,
   output logic [DATA_W-1:0] MemWData,
   input  logic [DATA_W-1:0] MemRData,
   input  logic              MemAck,
   output logic              Busy,
   output logic              WbValid,
   output logic [DATA_W-1:0] WbData,
   output logic [4:0]        WbRd,
   output logic              WbRegWrite,
   input  logic              ErrClr,
   output logic              ErrTimeout,
   output logic              ErrCtrl
`ifdef MISALIGN_TRAP_EN
   ,
   output logic              ErrMisalign
`endif
);

   localparam int unsigned CntW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam bit          TimeoutEn = (TIMEOUT_CYCLES != 0);
   localparam logic [CntW-1:0] CntLast =
      CntW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   typedef enum logic [0:0] {StIdle, StAccess} state_e;

   state_e          r_state;
   logic [CntW-1:0] r_cnt;
   logic [4:0]      r_rd;
   logic            r_regwr;
   logic            r_dmem1;
   logic            w_req;
   logic            w_timeout_hit;

   assign w_req         = ~DmemREB | ~DmemWEB;
   assign w_timeout_hit = TimeoutEn && (r_cnt == CntLast);

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         r_state    <= StIdle;
         r_cnt      <= '0;
         r_rd       <= '0;
         r_regwr    <= 1'b0;
         r_dmem1    <= 1'b0;
         MemREB     <= 1'b1;
         MemWEB     <= 1'b1;
         MemAddr    <= '0;
         MemWData   <= '0;
         Busy       <= 1'b0;
         WbValid    <= 1'b0;
         WbData     <= '0;
         WbRd       <= '0;
         WbRegWrite <= 1'b0;
         ErrTimeout <= 1'b0;
         ErrCtrl    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
         ErrMisalign <= 1'b0;
`endif
      end else begin
         WbValid <= 1'b0;
         // Clear first so a set event later in this block overrides it
         if (ErrClr) begin
            ErrTimeout <= 1'b0;
            ErrCtrl    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            ErrMisalign <= 1'b0;
`endif
         end
         unique case (r_state)
            StIdle: begin
               if (ExValid) begin
                  if (!DmemREB && !DmemWEB) begin
                     ErrCtrl    <= 1'b1;
                     WbValid    <= 1'b1;
                     WbRegWrite <= 1'b0;
`ifdef MISALIGN_TRAP_EN
                  end else if (w_req && (ALUResult[1:0] != 2'b00)) begin
                     ErrMisalign <= 1'b1;
                     WbValid     <= 1'b1;
                     WbRegWrite  <= 1'b0;
`endif
                  end else if (w_req) begin
                     MemAddr  <= ALUResult;
                     MemWData <= StoreData;
                     MemREB   <= DmemREB;
                     MemWEB   <= DmemWEB;
                     Busy     <= 1'b1;
                     r_state  <= StAccess;
                     r_cnt    <= '0;
                     r_rd     <= RdIn;
                     r_regwr  <= RegWriteIn & DmemWEB;
                     r_dmem1  <= Dmem1ALUOUT;
                  end else begin
                     WbValid    <= 1'b1;
                     WbData     <= ALUResult;
                     WbRd       <= RdIn;
                     WbRegWrite <= RegWriteIn;
                  end
               end
            end
            StAccess: begin
               if (MemAck) begin
                  MemREB     <= 1'b1;
                  MemWEB     <= 1'b1;
                  Busy       <= 1'b0;
                  r_state    <= StIdle;
                  WbValid    <= 1'b1;
                  WbData     <= r_dmem1 ? MemRData : MemAddr;
                  WbRd       <= r_rd;
                  WbRegWrite <= r_regwr;
               end else if (w_timeout_hit) begin
                  MemREB     <= 1'b1;
                  MemWEB     <= 1'b1;
                  Busy       <= 1'b0;
                  r_state    <= StIdle;
                  ErrTimeout <= 1'b1;
                  WbValid    <= 1'b1;
                  WbRd       <= r_rd;
                  WbRegWrite <= 1'b0;
               end else if (r_cnt != '1) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (built with TIMEOUT_CYCLES=4).
module tb_mem_access_stage;

   logic        CLK = 1'b0;
   logic        RSTB;
   logic        ExValid;
   logic [31:0] ALUResult;
   logic [31:0] StoreData;
   logic        Dmem1ALUOUT;
   logic        DmemREB;
   logic        DmemWEB;
   logic [4:0]  RdIn;
   logic        RegWriteIn;
   logic        MemREB;
   logic        MemWEB;
   logic [31:0] MemAddr;
   logic [31:0] MemWData;
   logic [31:0] MemRData;
   logic        MemAck;
   logic        Busy;
   logic        WbValid;
   logic [31:0] WbData;
   logic [4:0]  WbRd;
   logic        WbRegWrite;
   logic        ErrClr;
   logic        ErrTimeout;
   logic        ErrCtrl;
`ifdef MISALIGN_TRAP_EN
   logic        ErrMisalign;
`endif

   int checks   = 0;
   int failures = 0;

   mem_access_stage #(
      .DATA_W         (32),
      .TIMEOUT_CYCLES (4)
   ) u_dut (
      .CLK         (CLK),
      .RSTB        (RSTB),
      .ExValid     (ExValid),
      .ALUResult   (ALUResult),
      .StoreData   (StoreData),
      .Dmem1ALUOUT (Dmem1ALUOUT),
      .DmemREB     (DmemREB),
      .DmemWEB     (DmemWEB),
      .RdIn        (RdIn),
      .RegWriteIn  (RegWriteIn),
      .MemREB      (MemREB),
      .MemWEB      (MemWEB),
      .MemAddr     (MemAddr),
      .MemWData    (MemWData),
      .MemRData    (MemRData),
      .MemAck      (MemAck),
      .Busy        (Busy),
      .WbValid     (WbValid),
      .WbData      (WbData),
      .WbRd        (WbRd),
      .WbRegWrite  (WbRegWrite),
      .ErrClr      (ErrClr),
      .ErrTimeout  (ErrTimeout),
      .ErrCtrl     (ErrCtrl)
`ifdef MISALIGN_TRAP_EN
      ,
      .ErrMisalign (ErrMisalign)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      ExValid     = 1'b0;
      DmemREB     = 1'b1;
      DmemWEB     = 1'b1;
      Dmem1ALUOUT = 1'b0;
      MemAck      = 1'b0;
      ErrClr      = 1'b0;
   endtask

   task automatic load_req(input logic [31:0] addr, input logic [4:0] rd);
      ExValid     = 1'b1;
      DmemREB     = 1'b0;
      DmemWEB     = 1'b1;
      Dmem1ALUOUT = 1'b1;
      ALUResult   = addr;
      RdIn        = rd;
      RegWriteIn  = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RSTB      = 1'b0;
      ALUResult = '0;
      StoreData = '0;
      RdIn      = '0;
      RegWriteIn = 1'b0;
      MemRData  = '0;
      idle_inputs();
      step();
      step();
      chk1("rst_memreb", MemREB, 1'b1);
      chk1("rst_memweb", MemWEB, 1'b1);
      chk1("rst_busy", Busy, 1'b0);
      chk1("rst_wbvalid", WbValid, 1'b0);
      chk32("rst_memaddr", MemAddr, 32'h0);
      chk32("rst_wbdata", WbData, 32'h0);
      chk1("rst_errto", ErrTimeout, 1'b0);
      chk1("rst_errctrl", ErrCtrl, 1'b0);
      RSTB = 1'b1;
      step();

      // Three back-to-back ALU ops
      ExValid = 1'b1; ALUResult = 32'h5; RdIn = 5'd3; RegWriteIn = 1'b1;
      step();
      chk1("alu0_valid", WbValid, 1'b1);
      chk32("alu0_data", WbData, 32'h5);
      chk32("alu0_rd", {27'b0, WbRd}, 32'd3);
      chk1("alu0_rw", WbRegWrite, 1'b1);
      ALUResult = 32'h7; RdIn = 5'd4; RegWriteIn = 1'b0;
      step();
      chk1("alu1_valid", WbValid, 1'b1);
      chk32("alu1_data", WbData, 32'h7);
      chk32("alu1_rd", {27'b0, WbRd}, 32'd4);
      chk1("alu1_rw", WbRegWrite, 1'b0);
      ALUResult = 32'h9; RdIn = 5'd5; RegWriteIn = 1'b1;
      step();
      chk1("alu2_valid", WbValid, 1'b1);
      chk32("alu2_data", WbData, 32'h9);
      idle_inputs();
      MemAck = 1'b1;  // ignored in IDLE
      step();
      chk1("idle_wbvalid", WbValid, 1'b0);
      chk1("idle_ack_busy", Busy, 1'b0);
      chk32("idle_hold", WbData, 32'h9);
      MemAck = 1'b0;

      // Load with two wait states, ack in third ACCESS cycle
      load_req(32'h100, 5'd7);
      step();
      chk1("ld_c1_reb", MemREB, 1'b0);
      chk1("ld_c1_busy", Busy, 1'b1);
      chk32("ld_c1_addr", MemAddr, 32'h100);
      chk1("ld_c1_wbvalid", WbValid, 1'b0);
      step();
      chk1("ld_c2_reb", MemREB, 1'b0);
      chk1("ld_c2_busy", Busy, 1'b1);
      step();
      chk1("ld_c3_reb", MemREB, 1'b0);
      chk1("ld_c3_busy", Busy, 1'b1);
      MemAck = 1'b1; MemRData = 32'hDEADBEEF;
      step();
      chk1("ld_done_reb", MemREB, 1'b1);
      chk1("ld_done_busy", Busy, 1'b0);
      chk1("ld_done_valid", WbValid, 1'b1);
      chk32("ld_done_data", WbData, 32'hDEADBEEF);
      chk32("ld_done_rd", {27'b0, WbRd}, 32'd7);
      chk1("ld_done_rw", WbRegWrite, 1'b1);
      idle_inputs();
      step();
      chk1("ld_after_valid", WbValid, 1'b0);

      // Store with zero wait states
      ExValid = 1'b1; DmemWEB = 1'b0; ALUResult = 32'h200; StoreData = 32'h1234;
      RdIn = 5'd9; RegWriteIn = 1'b1;
      step();
      chk1("st_web", MemWEB, 1'b0);
      chk1("st_reb", MemREB, 1'b1);
      chk32("st_wdata", MemWData, 32'h1234);
      chk1("st_busy", Busy, 1'b1);
      MemAck = 1'b1;
      step();
      chk1("st_done_web", MemWEB, 1'b1);
      chk1("st_done_valid", WbValid, 1'b1);
      chk1("st_done_rw", WbRegWrite, 1'b0);
      chk32("st_done_data", WbData, 32'h200);
      idle_inputs();
      step();

      // Timeout: no ack, abort after 4 ACCESS cycles
      load_req(32'h300, 5'd2);
      step();
      step();
      step();
      step();
      chk1("to_c4_reb", MemREB, 1'b0);
      chk1("to_c4_busy", Busy, 1'b1);
      chk1("to_c4_err", ErrTimeout, 1'b0);
      step();
      chk1("to_reb", MemREB, 1'b1);
      chk1("to_busy", Busy, 1'b0);
      chk1("to_err", ErrTimeout, 1'b1);
      chk1("to_valid", WbValid, 1'b1);
      chk1("to_rw", WbRegWrite, 1'b0);
      idle_inputs();
      step();
      chk1("to_sticky", ErrTimeout, 1'b1);
      ErrClr = 1'b1;
      step();
      chk1("to_clr", ErrTimeout, 1'b0);
      ErrClr = 1'b0;

      // Ack on the would-be abort edge completes normally
      load_req(32'h304, 5'd6);
      step();
      step();
      step();
      step();
      MemAck = 1'b1; MemRData = 32'hCAFEF00D;
      step();
      chk1("race_err", ErrTimeout, 1'b0);
      chk1("race_valid", WbValid, 1'b1);
      chk1("race_rw", WbRegWrite, 1'b1);
      chk32("race_data", WbData, 32'hCAFEF00D);
      idle_inputs();
      step();

      // Illegal control with simultaneous clear: set wins
      ExValid = 1'b1; DmemREB = 1'b0; DmemWEB = 1'b0; RegWriteIn = 1'b1; ErrClr = 1'b1;
      step();
      chk1("ctrl_err", ErrCtrl, 1'b1);
      chk1("ctrl_reb", MemREB, 1'b1);
      chk1("ctrl_web", MemWEB, 1'b1);
      chk1("ctrl_busy", Busy, 1'b0);
      chk1("ctrl_valid", WbValid, 1'b1);
      chk1("ctrl_rw", WbRegWrite, 1'b0);
      idle_inputs();
      ErrClr = 1'b1;
      step();
      chk1("ctrl_clr", ErrCtrl, 1'b0);
      ErrClr = 1'b0;

      // Unaligned load
      load_req(32'h102, 5'd8);
      step();
`ifdef MISALIGN_TRAP_EN
      chk1("mis_err", ErrMisalign, 1'b1);
      chk1("mis_reb", MemREB, 1'b1);
      chk1("mis_busy", Busy, 1'b0);
      chk1("mis_valid", WbValid, 1'b1);
      chk1("mis_rw", WbRegWrite, 1'b0);
      idle_inputs();
      ErrClr = 1'b1;
      step();
      chk1("mis_clr", ErrMisalign, 1'b0);
      ErrClr = 1'b0;
`else
      chk1("unal_reb", MemREB, 1'b0);
      chk32("unal_addr", MemAddr, 32'h102);
      MemAck = 1'b1; MemRData = 32'h55AA;
      step();
      chk1("unal_valid", WbValid, 1'b1);
      chk32("unal_data", WbData, 32'h55AA);
      idle_inputs();
      step();
`endif

      // Asynchronous reset in the middle of an access
      load_req(32'h400, 5'd1);
      step();
      chk1("ar_reb_pre", MemREB, 1'b0);
      #2;
      RSTB = 1'b0;
      #1;
      chk1("ar_reb", MemREB, 1'b1);
      chk1("ar_busy", Busy, 1'b0);
      idle_inputs();
      step();
      RSTB = 1'b1;
      step();
      chk1("ar_post_busy", Busy, 1'b0);
      chk1("ar_post_valid", WbValid, 1'b0);
      chk1("ar_post_reb", MemREB, 1'b1);
      chk1("ar_post_errto", ErrTimeout, 1'b0);
      chk1("ar_post_errctrl", ErrCtrl, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
